// File: rtl/seat_pkg.sv
// Shared types for the seat-table controller.
// Holds the seat state, request opcode, response status and control FSM
// encodings used by the interface, the per-seat timers and the top.
package seat_pkg;

    localparam int SEAT_STATE_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'b00,
        ST_RESERVED = 2'b01,
        ST_AWAY     = 2'b10,
        ST_OCCUPIED = 2'b11
    } seat_state_t;

    typedef enum logic [1:0] {
        OP_RESERVE = 2'd0,
        OP_CHECKIN = 2'd1,
        OP_AWAY    = 2'd2,
        OP_RELEASE = 2'd3
    } seat_op_t;

    typedef enum logic [2:0] {
        STS_OK        = 3'd0,
        STS_BAD_SEAT  = 3'd1,
        STS_BAD_SID   = 3'd2,
        STS_SEAT_BUSY = 3'd3,
        STS_HAS_SEAT  = 3'd4,
        STS_NOT_OWNER = 3'd5,
        STS_BAD_STATE = 3'd6
    } seat_status_t;

    typedef enum logic [1:0] {
        FSM_IDLE = 2'd0,
        FSM_EVAL = 2'd1,
        FSM_RESP = 2'd2
    } fsm_state_t;

endpackage

// File: rtl/seat_manager_if.sv
// Request/response bus of the seat-table controller.
//   req_valid/req_ready : request handshake
//   req_op/req_sid/req_seat : request payload
//   rsp_valid/rsp_status/rsp_state : one-cycle response
// master = requester side, slave = seat_manager side.
interface seat_manager_if
    import seat_pkg::*;
#(
    parameter int SID_W = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [1:0]              req_op;
    logic [SID_W-1:0]        req_sid;
    logic [7:0]              req_seat;
    logic                    rsp_valid;
    logic [2:0]              rsp_status;
    logic [SEAT_STATE_W-1:0] rsp_state;

    modport master (
        output req_valid, req_op, req_sid, req_seat,
        input  req_ready, rsp_valid, rsp_status, rsp_state
    );

    modport slave (
        input  req_valid, req_op, req_sid, req_seat,
        output req_ready, rsp_valid, rsp_status, rsp_state
    );
endinterface

// File: rtl/seat_timer.sv
// Per-seat countdown timer.
//   clk, rst_n  : clock, async active-low reset
//   i_tick      : time-unit pulse
//   i_load      : load i_load_val (has priority over counting)
//   i_load_val  : value loaded on i_load
//   i_hold      : seat is RESERVED/AWAY and not being written this cycle
//   o_expire    : combinational, high in the cycle whose tick takes the count 1 -> 0
module seat_timer #(
    parameter int TIMER_W = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_tick,
    input  logic               i_load,
    input  logic [TIMER_W-1:0] i_load_val,
    input  logic               i_hold,
    output logic               o_expire
);
    logic [TIMER_W-1:0] r_count;

    assign o_expire = i_hold && i_tick && (r_count == TIMER_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_hold && i_tick && (r_count != '0)) begin
            r_count <= r_count - TIMER_W'(1);
        end
    end
endmodule

// File: rtl/seat_manager.sv
// Seat-table controller: state, owner and countdown per seat, serialising
// RESERVE/CHECKIN/AWAY/RELEASE requests and expiring stale holds on tick.
//   clk, rst_n   : clock, async active-low reset
//   tick         : time-unit pulse
//   bus          : request/response interface (slave side)
//   query_seat   : table read address; query_state/query_sid combinational read
//   expire_mask  : one-cycle pulse per seat that expired
//   free_count   : registered count of EMPTY seats
//
// state | meaning
// IDLE  | req_ready high, latch request on handshake
// EVAL  | evaluate against the table, commit write at the exit edge
// RESP  | rsp_valid high for one cycle
module seat_manager
    import seat_pkg::*;
#(
    parameter int  NUM_SEATS    = 32,
    parameter int  SID_W        = 32,
    parameter int  TIMER_W      = 11,
    parameter int  RESV_TIMEOUT = 30,
    parameter int  AWAY_TIMEOUT = 60,
    localparam int SEAT_W       = $clog2(NUM_SEATS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tick,
    seat_manager_if.slave           bus,
    input  logic [SEAT_W-1:0]       query_seat,
    output logic [SEAT_STATE_W-1:0] query_state,
    output logic [SID_W-1:0]        query_sid,
    output logic [NUM_SEATS-1:0]    expire_mask,
    output logic [SEAT_W:0]         free_count
);
    fsm_state_t         r_fsm, w_fsm_nxt;
    logic               w_ready, w_rsp_valid;

    seat_op_t           r_op;
    logic [SID_W-1:0]   r_sid;
    logic [7:0]         r_seat;

    seat_state_t        r_seat_state [NUM_SEATS];
    logic [SID_W-1:0]   r_owner      [NUM_SEATS];

    logic [NUM_SEATS-1:0] w_sid_match, w_load, w_hold, w_expire;
    logic [NUM_SEATS-1:0] r_expire_mask;
    logic [SEAT_W:0]      w_free_cnt, r_free_count;

    logic [SEAT_W-1:0]  w_idx;
    logic               w_bad_seat, w_has_seat, w_is_owner, w_wr_en;
    seat_state_t        w_cur_state, w_new_state, w_rsp_state;
    logic [SID_W-1:0]   w_cur_owner, w_new_owner;
    logic [TIMER_W-1:0] w_new_timer;
    seat_status_t       w_status;
    seat_status_t       r_rsp_status;
    seat_state_t        r_rsp_state;

    // Out-of-range seats alias onto low table entries; w_bad_seat gates every use.
    assign w_idx       = r_seat[SEAT_W-1:0];
    assign w_bad_seat  = {1'b0, r_seat} >= 9'(NUM_SEATS);
    assign w_cur_state = r_seat_state[w_idx];
    assign w_cur_owner = r_owner[w_idx];
    assign w_is_owner  = (w_cur_state != ST_EMPTY) && (w_cur_owner == r_sid);

    // Owner 0 marks an empty seat and sid 0 is rejected first, so a raw compare is safe.
    always_comb begin
        for (int i = 0; i < NUM_SEATS; i++) begin
            w_sid_match[i] = (r_owner[i] == r_sid);
        end
    end
    assign w_has_seat = |w_sid_match;

    always_comb begin
        w_status    = STS_OK;
        w_new_state = w_cur_state;
        w_new_owner = w_cur_owner;
        w_new_timer = '0;
        if (w_bad_seat) begin
            w_status = STS_BAD_SEAT;
        end else if (r_sid == '0) begin
            w_status = STS_BAD_SID;
        end else begin
            case (r_op)
                OP_RESERVE: begin
                    if (w_cur_state != ST_EMPTY) begin
                        w_status = STS_SEAT_BUSY;
                    end else if (w_has_seat) begin
                        w_status = STS_HAS_SEAT;
                    end else begin
                        w_new_state = ST_RESERVED;
                        w_new_owner = r_sid;
                        w_new_timer = TIMER_W'(RESV_TIMEOUT);
                    end
                end
                OP_CHECKIN: begin
                    if (!w_is_owner) begin
                        w_status = STS_NOT_OWNER;
                    end else if (w_cur_state == ST_OCCUPIED) begin
                        w_status = STS_BAD_STATE;
                    end else begin
                        w_new_state = ST_OCCUPIED;
                    end
                end
                OP_AWAY: begin
                    if (!w_is_owner) begin
                        w_status = STS_NOT_OWNER;
                    end else if (w_cur_state != ST_OCCUPIED) begin
                        w_status = STS_BAD_STATE;
                    end else begin
                        w_new_state = ST_AWAY;
                        w_new_timer = TIMER_W'(AWAY_TIMEOUT);
                    end
                end
                OP_RELEASE: begin
                    if (!w_is_owner) begin
                        w_status = STS_NOT_OWNER;
                    end else begin
                        w_new_state = ST_EMPTY;
                        w_new_owner = '0;
                    end
                end
                default: w_status = STS_BAD_STATE;
            endcase
        end
    end

    assign w_wr_en     = (r_fsm == FSM_EVAL) && (w_status == STS_OK);
    assign w_rsp_state = w_bad_seat ? ST_EMPTY : w_new_state;

    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_ready     = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_fsm)
            FSM_IDLE: begin
                w_ready = 1'b1;
                if (bus.req_valid) w_fsm_nxt = FSM_EVAL;
            end
            FSM_EVAL: w_fsm_nxt = FSM_RESP;
            FSM_RESP: begin
                w_rsp_valid = 1'b1;
                w_fsm_nxt   = FSM_IDLE;
            end
            default: w_fsm_nxt = FSM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm <= FSM_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= OP_RESERVE;
            r_sid        <= '0;
            r_seat       <= '0;
            r_rsp_status <= STS_OK;
            r_rsp_state  <= ST_EMPTY;
        end else begin
            if ((r_fsm == FSM_IDLE) && bus.req_valid) begin
                r_op   <= seat_op_t'(bus.req_op);
                r_sid  <= bus.req_sid;
                r_seat <= bus.req_seat;
            end
            if (r_fsm == FSM_EVAL) begin
                r_rsp_status <= w_status;
                r_rsp_state  <= w_rsp_state;
            end
        end
    end

    // The written seat drops its hold, so a coincident tick cannot touch the fresh timer.
    for (genvar g = 0; g < NUM_SEATS; g++) begin : g_seat
        assign w_load[g] = w_wr_en && (w_idx == SEAT_W'(g));
        assign w_hold[g] = ((r_seat_state[g] == ST_RESERVED) || (r_seat_state[g] == ST_AWAY))
                           && !w_load[g];
        seat_timer #(
            .TIMER_W (TIMER_W)
        ) u_timer (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_tick     (tick),
            .i_load     (w_load[g]),
            .i_load_val (w_new_timer),
            .i_hold     (w_hold[g]),
            .o_expire   (w_expire[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SEATS; i++) begin
                r_seat_state[i] <= ST_EMPTY;
                r_owner[i]      <= '0;
            end
            r_expire_mask <= '0;
        end else begin
            for (int i = 0; i < NUM_SEATS; i++) begin
                if (w_load[i]) begin
                    r_seat_state[i] <= w_new_state;
                    r_owner[i]      <= w_new_owner;
                end else if (w_expire[i]) begin
                    r_seat_state[i] <= ST_EMPTY;
                    r_owner[i]      <= '0;
                end
            end
            r_expire_mask <= w_expire;
        end
    end

    always_comb begin
        w_free_cnt = '0;
        for (int i = 0; i < NUM_SEATS; i++) begin
            if (r_seat_state[i] == ST_EMPTY) w_free_cnt = w_free_cnt + (SEAT_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_free_count <= (SEAT_W+1)'(NUM_SEATS);
        end else begin
            r_free_count <= w_free_cnt;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_status = r_rsp_status;
    assign bus.rsp_state  = r_rsp_state;
    assign query_state    = r_seat_state[query_seat];
    assign query_sid      = r_owner[query_seat];
    assign expire_mask    = r_expire_mask;
    assign free_count     = r_free_count;
endmodule

// File: tb/tb_seat_manager.sv
// Directed bench for seat_manager (32 seats, 30/60 tick timeouts).
module tb_seat_manager;
    localparam logic [1:0]  RESERVE = 2'd0, CHECKIN = 2'd1, AWAY = 2'd2, RELEASE = 2'd3;
    localparam logic [2:0]  OK = 3'd0, BAD_SEAT = 3'd1, BAD_SID = 3'd2, SEAT_BUSY = 3'd3,
                            HAS_SEAT = 3'd4, NOT_OWNER = 3'd5, BAD_STATE = 3'd6;
    localparam logic [31:0] SA = 32'h01FF_FFFF, SB = 32'h0000_0ABC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [4:0]  query_seat = '0;
    logic [1:0]  query_state;
    logic [31:0] query_sid;
    logic [31:0] expire_mask;
    logic [5:0]  free_count;
    logic [31:0] mask;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    seat_manager_if #(.SID_W(32)) bus ();

    seat_manager #(
        .NUM_SEATS(32), .SID_W(32), .TIMER_W(11), .RESV_TIMEOUT(30), .AWAY_TIMEOUT(60)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .bus         (bus),
        .query_seat  (query_seat),
        .query_state (query_state),
        .query_sid   (query_sid),
        .expire_mask (expire_mask),
        .free_count  (free_count)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic query(input string tag, input logic [4:0] seat,
                         input logic [1:0] exp_state, input logic [31:0] exp_sid);
        query_seat = seat;
        #1;
        check({tag, "_state"}, query_state, exp_state);
        check({tag, "_sid"}, query_sid, exp_sid);
    endtask

    task automatic do_tick(input int n);
        repeat (n) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    // Ends on the negedge of the response cycle; mask is expire_mask seen there.
    task automatic do_req(input string tag, input logic [1:0] op, input logic [31:0] sid,
                          input logic [7:0] seat, input logic [2:0] exp_status,
                          input logic [1:0] exp_state, input bit tick_eval,
                          output logic [31:0] mask_at_rsp);
        int n;
        @(negedge clk);
        check({tag, "_ready"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_sid   = sid;
        bus.req_seat  = seat;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check({tag, "_early_rsp"}, bus.rsp_valid, 0);
        if (tick_eval) tick = 1'b1;
        n = 1;
        do begin
            @(negedge clk);
            tick = 1'b0;
            n++;
        end while (!bus.rsp_valid && n < 8);
        check({tag, "_latency"}, n, 2);
        check({tag, "_status"}, bus.rsp_status, exp_status);
        check({tag, "_rsp_state"}, bus.rsp_state, exp_state);
        mask_at_rsp = expire_mask;
    endtask

    initial begin
        bit saw_rsp;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_sid   = '0;
        bus.req_seat  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_status", bus.rsp_status, 0);
        check("rst_rsp_state", bus.rsp_state, 0);
        check("rst_expire", expire_mask, 0);
        check("rst_free", free_count, 32);
        for (int i = 0; i < 32; i++) query($sformatf("rst_q%0d", i), 5'(i), 2'b00, 32'h0);

        // Basic lifecycle on seat 1
        do_req("res1", RESERVE, SA, 8'd1, OK, 2'b01, 0, mask);
        @(negedge clk);
        check("free_after_res", free_count, 31);
        do_req("res2_dup", RESERVE, SA, 8'd2, HAS_SEAT, 2'b00, 0, mask);
        do_req("chk1", CHECKIN, SA, 8'd1, OK, 2'b11, 0, mask);
        do_req("away1", AWAY, SA, 8'd1, OK, 2'b10, 0, mask);
        do_req("chk1b", CHECKIN, SA, 8'd1, OK, 2'b11, 0, mask);
        do_req("rel1", RELEASE, SA, 8'd1, OK, 2'b00, 0, mask);
        @(negedge clk);
        check("free_after_rel", free_count, 32);
        query("q1_rel", 5'd1, 2'b00, 32'h0);

        // Reservation timeout on seat 5
        do_req("res5", RESERVE, SA, 8'd5, OK, 2'b01, 0, mask);
        do_tick(29);
        query("q5_t29", 5'd5, 2'b01, SA);
        check("mask_t29", expire_mask, 0);
        do_tick(1);
        check("mask_t30", expire_mask, 32'h0000_0020);
        query("q5_t30", 5'd5, 2'b00, 32'h0);
        @(negedge clk);
        check("mask_cleared", expire_mask, 0);
        check("free_after_exp", free_count, 32);

        // Error codes
        do_req("bad_seat", RESERVE, SA, 8'd40, BAD_SEAT, 2'b00, 0, mask);
        do_req("bad_sid", RESERVE, 32'h0, 8'd3, BAD_SID, 2'b00, 0, mask);
        do_req("res3", RESERVE, SA, 8'd3, OK, 2'b01, 0, mask);
        do_req("chk3", CHECKIN, SA, 8'd3, OK, 2'b11, 0, mask);
        do_req("rel3_foreign", RELEASE, SB, 8'd3, NOT_OWNER, 2'b11, 0, mask);
        query("q3_foreign", 5'd3, 2'b11, SA);
        do_req("chk3_occ", CHECKIN, SA, 8'd3, BAD_STATE, 2'b11, 0, mask);
        do_req("res3_busy", RESERVE, SB, 8'd3, SEAT_BUSY, 2'b11, 0, mask);
        do_req("chk4_empty", CHECKIN, SB, 8'd4, NOT_OWNER, 2'b00, 0, mask);

        // Tick coincident with an AWAY commit, while another AWAY seat expires
        do_req("res2", RESERVE, SB, 8'd2, OK, 2'b01, 0, mask);
        do_req("chk2", CHECKIN, SB, 8'd2, OK, 2'b11, 0, mask);
        do_req("away3", AWAY, SA, 8'd3, OK, 2'b10, 0, mask);
        do_tick(59);
        query("q3_t59", 5'd3, 2'b10, SA);
        do_req("away2_tick", AWAY, SB, 8'd2, OK, 2'b10, 1, mask);
        check("mask_seat3", mask, 32'h0000_0008);
        query("q3_expired", 5'd3, 2'b00, 32'h0);
        do_tick(59);
        query("q2_t59", 5'd2, 2'b10, SB);
        check("mask2_t59", expire_mask, 0);
        do_tick(1);
        check("mask2_t60", expire_mask, 32'h0000_0004);
        query("q2_t60", 5'd2, 2'b00, 32'h0);
        @(negedge clk);
        check("free_all", free_count, 32);

        // Reset during EVAL
        do_req("res7", RESERVE, SA, 8'd7, OK, 2'b01, 0, mask);
        do_req("chk7", CHECKIN, SA, 8'd7, OK, 2'b11, 0, mask);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = RESERVE;
        bus.req_sid   = SB;
        bus.req_seat  = 8'd9;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        saw_rsp = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (bus.rsp_valid) saw_rsp = 1'b1;
        end
        check("rst_eval_no_rsp", saw_rsp, 0);
        query("q7_rst", 5'd7, 2'b00, 32'h0);
        query("q9_rst", 5'd9, 2'b00, 32'h0);
        check("rst_eval_free", free_count, 32);
        do_req("res9_after", RESERVE, SA, 8'd9, OK, 2'b01, 0, mask);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1);
    end
endmodule
